// File: rtl/seg_rx_display.sv
// Display value builder: assembles BYTES-byte RS485 frames (MSB first) and
// applies the selected display mode to a saturating accumulator once per refresh tick.
module seg_rx_display #(
    parameter int         TICK_CYCLES = 5_000_000,
    parameter int         GAP_CYCLES  = 50_000,
    parameter int         BYTES       = 3,
    parameter int         DATA_W      = 20,
    parameter int         MAX_VAL     = 999_999,
    parameter bit         SIGNED      = 1'b1,
    parameter logic [5:0] POINT_CFG   = 6'b000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    input  logic [1:0]        mode_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] data_o,
    output logic [5:0]        point_o,
    output logic              en_o,
    output logic              sign_o,
    output logic              frame_err_o,
    output logic              ovf_o
);

    localparam int FW = 8 * BYTES;
    localparam int SW = ((FW > DATA_W) ? FW : DATA_W) + 2;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_VAL);
    localparam logic signed [SW-1:0] MIN_S = SIGNED ? -MAX_S : '0;
    localparam logic signed [SW-1:0] ONE_S = SW'(1);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_ACCUM  = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    mode_e modeSel;

    logic [TW-1:0]          tickCnt_q, tickCnt_d;
    logic [2:0]             byteCnt_q, byteCnt_d;
    logic [GW-1:0]          gapCnt_q, gapCnt_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic [FW-1:0]          frameHold_q, frameHold_d;
    logic                   pending_q, pending_d;
    logic signed [SW-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   sign_q, sign_d;
    logic                   en_q, en_d;
    logic [5:0]             point_q, point_d;
    logic                   frameErr_q, frameErr_d;
    logic                   ovf_q, ovf_d;

    logic                   tick;
    logic                   frameDone;
    logic [FW-1:0]          frameShift;
    logic signed [SW-1:0]   frameVal;
    logic signed [SW-1:0]   candVal;
    logic signed [SW-1:0]   clampVal;
    logic                   clampHit;
    logic [SW-1:0]          magVal;

    assign modeSel = mode_e'(mode_i);
    assign tick    = (tickCnt_q == TW'(TICK_CYCLES - 1));

    // Refresh timing and frame assembly; a stalled partial frame is dropped
    // without disturbing a complete frame that is still waiting for its tick.
    always_comb begin
        tickCnt_d   = tick ? '0 : tickCnt_q + 1'b1;
        frame_d     = frame_q;
        frameHold_d = frameHold_q;
        byteCnt_d   = byteCnt_q;
        gapCnt_d    = gapCnt_q;
        frameDone   = 1'b0;
        frameErr_d  = 1'b0;
        frameShift  = FW'({frame_q, rx_data_i});

        if (rx_valid_i) begin
            frame_d  = frameShift;
            gapCnt_d = '0;
            if (byteCnt_q == 3'(BYTES - 1)) begin
                byteCnt_d   = '0;
                frameHold_d = frameShift;
                frameDone   = 1'b1;
            end else begin
                byteCnt_d = byteCnt_q + 1'b1;
            end
        end else if (byteCnt_q != '0) begin
            if (gapCnt_q == GW'(GAP_CYCLES - 1)) begin
                byteCnt_d  = '0;
                gapCnt_d   = '0;
                frameErr_d = 1'b1;
            end else begin
                gapCnt_d = gapCnt_q + 1'b1;
            end
        end

        // A frame finishing on the tick edge must survive to the next tick.
        if (frameDone) begin
            pending_d = 1'b1;
        end else if (tick) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Mode evaluation with saturation; clr overrides whatever the tick computed.
    always_comb begin
        if (SIGNED) begin
            frameVal = {{(SW - FW){frameHold_q[FW-1]}}, frameHold_q};
        end else begin
            frameVal = {{(SW - FW){1'b0}}, frameHold_q};
        end

        candVal = acc_q;
        case (modeSel)
            MODE_DIRECT: if (pending_q) candVal = frameVal;
            MODE_ACCUM:  if (pending_q) candVal = acc_q + frameVal;
            MODE_COUNT:  candVal = (acc_q == MAX_S) ? '0 : acc_q + ONE_S;
            default:     candVal = acc_q;
        endcase

        clampHit = 1'b0;
        if (candVal > MAX_S) begin
            clampVal = MAX_S;
            clampHit = 1'b1;
        end else if (candVal < MIN_S) begin
            clampVal = MIN_S;
            clampHit = 1'b1;
        end else begin
            clampVal = candVal;
        end
        magVal = clampVal[SW-1] ? -clampVal : clampVal;

        acc_d   = acc_q;
        data_d  = data_q;
        sign_d  = sign_q;
        en_d    = en_q;
        point_d = point_q;
        ovf_d   = 1'b0;

        if (tick) begin
            en_d    = 1'b1;
            point_d = POINT_CFG;
        end

        if (clr_i) begin
            acc_d  = '0;
            data_d = '0;
            sign_d = 1'b0;
        end else if (tick) begin
            acc_d  = clampVal;
            ovf_d  = clampHit;
            data_d = DATA_W'(magVal);
            sign_d = clampVal[SW-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tickCnt_q   <= '0;
            byteCnt_q   <= '0;
            gapCnt_q    <= '0;
            frame_q     <= '0;
            frameHold_q <= '0;
            pending_q   <= 1'b0;
            acc_q       <= '0;
            data_q      <= '0;
            sign_q      <= 1'b0;
            en_q        <= 1'b0;
            point_q     <= '0;
            frameErr_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            tickCnt_q   <= tickCnt_d;
            byteCnt_q   <= byteCnt_d;
            gapCnt_q    <= gapCnt_d;
            frame_q     <= frame_d;
            frameHold_q <= frameHold_d;
            pending_q   <= pending_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            sign_q      <= sign_d;
            en_q        <= en_d;
            point_q     <= point_d;
            frameErr_q  <= frameErr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign data_o      = data_q;
    assign sign_o      = sign_q;
    assign en_o        = en_q;
    assign point_o     = point_q;
    assign frame_err_o = frameErr_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_seg_rx_display.sv
// Bench for seg_rx_display: directed scenarios plus randomized traffic, all checked
// every cycle against an integer-arithmetic model of the display rules.
module tb_seg_rx_display;

    localparam int         TICK = 10;
    localparam int         GAP  = 20;
    localparam int         NB   = 3;
    localparam int         DW   = 20;
    localparam int         MAXV = 999_999;
    localparam logic [5:0] PCFG = 6'b010100;

    logic          clk_i      = 1'b0;
    logic          rst_i      = 1'b1;
    logic [7:0]    rx_data_i  = '0;
    logic          rx_valid_i = 1'b0;
    logic [1:0]    mode_i     = '0;
    logic          clr_i      = 1'b0;
    logic [DW-1:0] data_o;
    logic [5:0]    point_o;
    logic          en_o;
    logic          sign_o;
    logic          frame_err_o;
    logic          ovf_o;

    int checks   = 0;
    int failures = 0;

    // Model state: signed accumulator as a plain integer, byte queue for the partial frame.
    int  mAcc;
    bit  mPend;
    int  mHold;
    int  mQ[$];
    int  mIdle;
    bit  mEn;
    int  cyc;
    bit  expOvf;
    bit  expErr;

    int  errCount;
    int  errAt;
    int  rMode;
    int  rData;
    bit  rValid;
    bit  rClr;

    seg_rx_display #(
        .TICK_CYCLES (TICK),
        .GAP_CYCLES  (GAP),
        .BYTES       (NB),
        .DATA_W      (DW),
        .MAX_VAL     (MAXV),
        .SIGNED      (1'b1),
        .POINT_CFG   (PCFG)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .mode_i      (mode_i),
        .clr_i       (clr_i),
        .data_o      (data_o),
        .point_o     (point_o),
        .en_o        (en_o),
        .sign_o      (sign_o),
        .frame_err_o (frame_err_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of the reference behaviour, using the inputs applied before this edge.
    task automatic modelStep(input bit rv, input int rd, input int md, input bit cl);
        bit tick;
        bit done;
        int cand;
        cyc++;
        tick   = (cyc % TICK) == 0;
        expOvf = 1'b0;
        expErr = 1'b0;
        done   = 1'b0;
        if (tick) mEn = 1'b1;
        if (cl) begin
            mAcc = 0;
        end else if (tick) begin
            case (md)
                0:       cand = mPend ? mHold : mAcc;
                1:       cand = mPend ? mAcc + mHold : mAcc;
                2:       cand = (mAcc == MAXV) ? 0 : mAcc + 1;
                default: cand = mAcc;
            endcase
            if (cand > MAXV) begin
                cand   = MAXV;
                expOvf = 1'b1;
            end else if (cand < -MAXV) begin
                cand   = -MAXV;
                expOvf = 1'b1;
            end
            mAcc = cand;
        end
        if (rv) begin
            mQ.push_back(rd);
            mIdle = 0;
            if (mQ.size() == NB) begin
                mHold = (mQ[0] << 16) | (mQ[1] << 8) | mQ[2];
                if (mHold >= 8388608) mHold -= 16777216;
                mQ.delete();
                done = 1'b1;
            end
        end else if (mQ.size() > 0) begin
            mIdle++;
            if (mIdle == GAP) begin
                mQ.delete();
                mIdle  = 0;
                expErr = 1'b1;
            end
        end
        if (done) mPend = 1'b1;
        else if (tick) mPend = 1'b0;
    endtask

    task automatic applyStimulus(input bit rv, input int rd, input int md, input bit cl);
        rx_valid_i = rv;
        rx_data_i  = 8'(rd);
        mode_i     = 2'(md);
        clr_i      = cl;
        @(posedge clk_i);
        #1;
        modelStep(rv, rd, md, cl);
        checkOutput("data",     32'(data_o),      (mAcc < 0) ? -mAcc : mAcc);
        checkOutput("sign",     32'(sign_o),      (mAcc < 0) ? 1 : 0);
        checkOutput("en",       32'(en_o),        32'(mEn));
        checkOutput("point",    32'(point_o),     mEn ? 32'(PCFG) : 0);
        checkOutput("ovf",      32'(ovf_o),       32'(expOvf));
        checkOutput("frameErr", 32'(frame_err_o), 32'(expErr));
    endtask

    task automatic applyReset();
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = '0;
        clr_i      = 1'b0;
        mode_i     = '0;
        repeat (2) @(posedge clk_i);
        #1;
        cyc = 0; mAcc = 0; mPend = 0; mHold = 0; mIdle = 0; mEn = 0;
        mQ.delete();
        checkOutput("rstData",     32'(data_o),      0);
        checkOutput("rstSign",     32'(sign_o),      0);
        checkOutput("rstEn",       32'(en_o),        0);
        checkOutput("rstPoint",    32'(point_o),     0);
        checkOutput("rstOvf",      32'(ovf_o),       0);
        checkOutput("rstFrameErr", 32'(frame_err_o), 0);
        rst_i = 1'b0;
    endtask

    task automatic idle(input int md, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, md, 1'b0);
    endtask

    task automatic sendFrame(input int b0, input int b1, input int b2, input int md);
        applyStimulus(1'b1, b0, md, 1'b0);
        applyStimulus(1'b1, b1, md, 1'b0);
        applyStimulus(1'b1, b2, md, 1'b0);
    endtask

    // Advances at least one cycle and stops right after the next tick edge.
    task automatic waitTick(input int md);
        do applyStimulus(1'b0, 0, md, 1'b0);
        while ((cyc % TICK) != 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset();

        idle(0, TICK - 1);
        checkOutput("enBeforeFirstTick", 32'(en_o), 0);
        idle(0, 1);
        checkOutput("enFirstTick",   32'(en_o),   1);
        checkOutput("dataFirstTick", 32'(data_o), 0);

        sendFrame(8'h00, 8'h30, 8'h39, 0);
        waitTick(0);
        checkOutput("direct12345", 32'(data_o), 12345);
        checkOutput("direct12345Sign", 32'(sign_o), 0);
        sendFrame(8'hFF, 8'hFF, 8'hFE, 0);
        waitTick(0);
        checkOutput("directMinus2", 32'(data_o), 2);
        checkOutput("directMinus2Sign", 32'(sign_o), 1);

        sendFrame(8'h0F, 8'h42, 8'h40, 0);
        waitTick(0);
        checkOutput("satPosData", 32'(data_o), MAXV);
        checkOutput("satPosOvf",  32'(ovf_o),  1);
        idle(0, 1);
        checkOutput("ovfOneCycle", 32'(ovf_o), 0);
        sendFrame(8'h80, 8'h00, 8'h00, 0);
        waitTick(0);
        checkOutput("satNegData", 32'(data_o), MAXV);
        checkOutput("satNegSign", 32'(sign_o), 1);
        checkOutput("satNegOvf",  32'(ovf_o),  1);

        applyStimulus(1'b0, 0, 1, 1'b1);
        checkOutput("clrData", 32'(data_o), 0);
        sendFrame(8'h06, 8'h1A, 8'h80, 1);
        waitTick(1);
        checkOutput("accum400k", 32'(data_o), 400000);
        sendFrame(8'h06, 8'h1A, 8'h80, 1);
        waitTick(1);
        checkOutput("accum800k", 32'(data_o), 800000);
        sendFrame(8'h06, 8'h1A, 8'h80, 1);
        waitTick(1);
        checkOutput("accumSat", 32'(data_o), MAXV);
        checkOutput("accumSatOvf", 32'(ovf_o), 1);
        applyStimulus(1'b0, 0, 1, 1'b1);
        checkOutput("accumClr", 32'(data_o), 0);

        applyStimulus(1'b1, 8'h00, 0, 1'b0);
        applyStimulus(1'b1, 8'h01, 0, 1'b0);
        errCount = 0;
        errAt    = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b0);
            if (frame_err_o) begin
                errCount++;
                if (errAt == 0) errAt = k;
            end
        end
        checkOutput("gapErrPulses", errCount, 1);
        checkOutput("gapErrCycle",  errAt,    GAP);
        sendFrame(8'h00, 8'h00, 8'h07, 0);
        waitTick(0);
        checkOutput("afterGap7", 32'(data_o), 7);

        sendFrame(8'h0F, 8'h42, 8'h3E, 0);
        waitTick(0);
        checkOutput("preset999998", 32'(data_o), 999998);
        waitTick(2);
        checkOutput("count999999", 32'(data_o), MAXV);
        checkOutput("countNoOvfA", 32'(ovf_o),  0);
        waitTick(2);
        checkOutput("countWrap",   32'(data_o), 0);
        checkOutput("countNoOvfB", 32'(ovf_o),  0);

        while (((cyc + 3) % TICK) != 0) applyStimulus(1'b0, 0, 0, 1'b0);
        sendFrame(8'h00, 8'h00, 8'h2A, 0);
        checkOutput("onTickNotApplied", 32'(data_o), 0);
        waitTick(0);
        checkOutput("onTickApplied", 32'(data_o), 42);

        sendFrame(8'h00, 8'h00, 8'h05, 0);
        while (((cyc + 1) % TICK) != 0) applyStimulus(1'b0, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("clrOnTickData", 32'(data_o), 0);
        checkOutput("clrOnTickOvf",  32'(ovf_o),  0);
        waitTick(0);
        checkOutput("clrDropsPending", 32'(data_o), 0);

        applyStimulus(1'b1, 8'h12, 0, 1'b0);
        applyReset();
        sendFrame(8'h00, 8'h00, 8'h09, 0);
        waitTick(0);
        checkOutput("afterMidFrameReset", 32'(data_o), 9);

        rMode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) applyReset();
            if ($urandom_range(0, 199) == 0) rMode = $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 2) begin
                idle(rMode, $urandom_range(15, 30));
            end else begin
                rValid = $urandom_range(0, 99) < 35;
                rData  = $urandom_range(0, 255);
                rClr   = $urandom_range(0, 149) == 0;
                if (rValid && mQ.size() == 0) begin
                    case ($urandom_range(0, 3))
                        0:       rData = 8'h00;
                        1:       rData = 8'hFF;
                        2:       rData = $urandom_range(0, 15);
                        default: rData = rData;
                    endcase
                end
                applyStimulus(rValid, rData, rMode, rClr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
